// File: rtl/axi_r_pkg.sv
// Shared R-channel beat layout and arbiter state encoding.
// Beat packing: [42:35] RID, [34:3] RDATA, [2:1] RRESP, [0] RLAST.
package axi_r_pkg;
    localparam int RID_W     = 8;
    localparam int RDATA_W   = 32;
    localparam int RRESP_W   = 2;
    localparam int DATA_W    = RID_W + RDATA_W + RRESP_W + 1;

    localparam int RLAST_BIT = 0;
    localparam int RRESP_LSB = 1;
    localparam int RDATA_LSB = RRESP_LSB + RRESP_W;
    localparam int RID_LSB   = RDATA_LSB + RDATA_W;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;
endpackage

// File: rtl/axi_r_resp_arbiter_if.sv
// Bus-side R sources plus the FIFO write port shared by the response arbiter.
interface axi_r_resp_arbiter_if #(
    parameter int NUM_SLV = 3,
    parameter int DATA_W  = axi_r_pkg::DATA_W
);
    logic [NUM_SLV-1:0]        s_rvalid;
    logic [NUM_SLV*DATA_W-1:0] s_rdata;
    logic [NUM_SLV-1:0]        s_rready;
    logic                      fifo_not_full;
    logic                      fifo_wr_en;
    logic [DATA_W-1:0]         fifo_w_data;

    modport slave (
        input  s_rvalid, s_rdata, fifo_not_full,
        output s_rready, fifo_wr_en, fifo_w_data
    );

    modport master (
        output s_rvalid, s_rdata, fifo_not_full,
        input  s_rready, fifo_wr_en, fifo_w_data
    );
endinterface

// File: rtl/axi_r_resp_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after i_start, with wrap.
module rr_pick #(
    parameter int  N     = 3,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_start,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);
    logic [2*N-1:0] w_dbl;
    logic [N-1:0]   w_rot;
    logic [IDX_W:0] w_off;
    logic [IDX_W:0] w_sum;

    // Rotating a doubled copy puts the start position at bit 0.
    assign w_dbl = {i_req, i_req};
    assign w_rot = w_dbl[i_start +: N];

    always_comb begin
        w_off = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_rot[k]) w_off = (IDX_W + 1)'(k);
        end
    end

    assign w_sum = w_off + {1'b0, i_start};
    assign o_idx = (w_sum >= (IDX_W + 1)'(N)) ? IDX_W'(w_sum - (IDX_W + 1)'(N))
                                               : w_sum[IDX_W-1:0];
    assign o_any = |i_req;
endmodule

// File: rtl/axi_r_resp_arbiter.sv
// Burst-granular round-robin arbiter feeding one R-channel FIFO write port.
// State | meaning: IDLE = pick next requester; BURST = forward granted source until RLAST.
module axi_r_resp_arbiter
    import axi_r_pkg::*;
#(
    parameter int  NUM_SLV   = 3,
    parameter int  DATA_W    = axi_r_pkg::DATA_W,
    parameter int  MAX_BEATS = 16,
    localparam int GID_W     = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1,
    localparam int CNT_W     = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    axi_r_resp_arbiter_if.slave  bus,
    output logic                 o_busy,
    output logic [GID_W-1:0]     o_grant_id,
    output logic                 o_burst_err
);
    state_t             r_state;
    state_t             w_state_nxt;
    logic [GID_W-1:0]   r_grant_id;
    logic [GID_W-1:0]   r_rr_ptr;
    logic [CNT_W-1:0]   r_beat_cnt;
    logic               r_burst_err;

    logic [GID_W-1:0]   w_pick_idx;
    logic               w_pick_any;
    logic               w_gnt_valid;
    logic [DATA_W-1:0]  w_gnt_beat;
    logic               w_xfer;
    logic               w_last;
    logic [NUM_SLV-1:0] w_rready;
    logic               w_wr_en;
    logic [DATA_W-1:0]  w_w_data;

    rr_pick #(.N(NUM_SLV)) u_pick (
        .i_req   (bus.s_rvalid),
        .i_start (r_rr_ptr),
        .o_idx   (w_pick_idx),
        .o_any   (w_pick_any)
    );

    always_comb begin
        w_gnt_valid = 1'b0;
        w_gnt_beat  = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (r_grant_id == GID_W'(i)) begin
                w_gnt_valid = bus.s_rvalid[i];
                w_gnt_beat  = bus.s_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Reset is gated in here so the FIFO never sees a write during reset.
    assign w_xfer = (r_state == BURST) & ~i_rst & w_gnt_valid & bus.fifo_not_full;
    assign w_last = w_gnt_beat[RLAST_BIT];

    always_comb begin
        w_state_nxt = r_state;
        w_rready    = '0;
        w_wr_en     = 1'b0;
        w_w_data    = '0;
        case (r_state)
            IDLE: begin
                if (w_pick_any) w_state_nxt = BURST;
            end
            BURST: begin
                if (!i_rst) begin
                    for (int i = 0; i < NUM_SLV; i++) begin
                        if (r_grant_id == GID_W'(i)) w_rready[i] = bus.fifo_not_full;
                    end
                end
                w_wr_en = w_xfer;
                if (w_xfer) begin
                    w_w_data = w_gnt_beat;
                    if (w_last) w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_grant_id  <= '0;
            r_rr_ptr    <= '0;
            r_beat_cnt  <= '0;
            r_burst_err <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == IDLE && w_pick_any) r_grant_id <= w_pick_idx;
            if (w_xfer) begin
                if (w_last) begin
                    r_rr_ptr   <= (r_grant_id == GID_W'(NUM_SLV - 1)) ? '0 : r_grant_id + 1'b1;
                    r_beat_cnt <= '0;
                end else if (r_beat_cnt == CNT_W'(MAX_BEATS - 1)) begin
                    // Overlong burst: flag it but keep the grant until RLAST.
                    r_burst_err <= 1'b1;
                end else begin
                    r_beat_cnt <= r_beat_cnt + 1'b1;
                end
            end
        end
    end

    assign bus.s_rready    = w_rready;
    assign bus.fifo_wr_en  = w_wr_en;
    assign bus.fifo_w_data = w_w_data;
    assign o_busy          = (r_state == BURST);
    assign o_grant_id      = r_grant_id;
    assign o_burst_err     = r_burst_err;
endmodule

// File: tb/tb_axi_r_resp_arbiter.sv
// Bench for axi_r_resp_arbiter: cycle table, directed burst sequences, random traffic vs a queue model.
module tb_axi_r_resp_arbiter;
    localparam int N    = 3;
    localparam int DW   = 43;
    localparam int MAXB = 16;

    typedef logic [DW-1:0] beat_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       busy;
    logic       err;
    logic [1:0] gid;

    always #5 clk = ~clk;

    axi_r_resp_arbiter_if #(.NUM_SLV(N), .DATA_W(DW)) bus();

    axi_r_resp_arbiter #(.NUM_SLV(N), .DATA_W(DW), .MAX_BEATS(MAXB)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .bus         (bus),
        .o_busy      (busy),
        .o_grant_id  (gid),
        .o_burst_err (err)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic beat_t mk(input int src, input int b, input bit last);
        return {8'(8'h50 + src), 32'(32'hC0DE_0000 + src * 256 + b), 2'(src), last};
    endfunction

    // ---------------- table-driven cycle vectors ----------------
    typedef struct {
        bit       rst;
        logic [2:0] rv;
        logic [2:0] last;
        int       beat;
        bit       nf;
        bit       e_busy;
        bit       chk_gid;
        int       e_gid;
        logic [2:0] e_rdy;
        bit       e_wr;
        int       e_src;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(bit r, logic [2:0] rv, logic [2:0] l, int b, bit nf,
                               bit eb, bit cg, int eg, logic [2:0] er, bit ew, int es);
        vec_t t;
        t.rst = r; t.rv = rv; t.last = l; t.beat = b; t.nf = nf;
        t.e_busy = eb; t.chk_gid = cg; t.e_gid = eg; t.e_rdy = er; t.e_wr = ew; t.e_src = es;
        return t;
    endfunction

    // ---------------- model-driven engine ----------------
    typedef struct {
        int    src;
        beat_t d;
        int    cyc;
    } wr_t;

    beat_t q[N][$];
    bit    hold[N];
    bit    nf_q[$];
    wr_t   log_q[$];
    bit    rand_valid;
    int    nf_pct;
    int    cyc;
    int    m_owner;
    int    m_start;
    int    m_beats;
    bit    m_err;

    function automatic bit pending();
        return (q[0].size() > 0) || (q[1].size() > 0) || (q[2].size() > 0) || (m_owner >= 0);
    endfunction

    task automatic hw_reset();
        rst = 1'b1;
        bus.s_rvalid = '0;
        bus.s_rdata = '0;
        bus.fifo_not_full = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        m_owner = -1; m_start = 0; m_beats = 0; m_err = 0;
        for (int i = 0; i < N; i++) begin
            hold[i] = 0;
            q[i].delete();
        end
        nf_q.delete();
        log_q.delete();
        rand_valid = 0;
        nf_pct = 100;
        cyc = 0;
    endtask

    task automatic push_burst(input int src, input int len, input int base);
        for (int b = 0; b < len; b++) q[src].push_back(mk(src, base + b, b == len - 1));
    endtask

    task automatic run_cycle();
        logic [N-1:0] vv;
        bit           nf;
        logic [N-1:0] e_rdy;
        bit           e_wr;
        beat_t        e_d;
        beat_t        popped;
        int           g;
        for (int i = 0; i < N; i++) begin
            vv[i] = (q[i].size() > 0) && (hold[i] || !rand_valid || $urandom_range(0, 3) != 0);
            bus.s_rdata[i*DW +: DW] = (q[i].size() > 0) ? q[i][0] : '0;
        end
        if (nf_q.size() > 0) nf = nf_q.pop_front();
        else nf = ($urandom_range(0, 99) < nf_pct);
        bus.s_rvalid = vv;
        bus.fifo_not_full = nf;
        #1;
        e_rdy = '0; e_wr = 0; e_d = '0; g = m_owner;
        if (g >= 0) begin
            e_rdy[g] = nf;
            e_wr = vv[g] & nf;
            if (e_wr) e_d = q[g][0];
        end
        check("busy", 64'(busy), 64'(g >= 0));
        if (g >= 0) check("grant_id", 64'(gid), 64'(g));
        check("s_rready", 64'(bus.s_rready), 64'(e_rdy));
        check("fifo_wr_en", 64'(bus.fifo_wr_en), 64'(e_wr));
        check("fifo_w_data", 64'(bus.fifo_w_data), 64'(e_d));
        check("burst_err", 64'(err), 64'(m_err));
        if (g >= 0) begin
            if (e_wr) begin
                log_q.push_back('{src: g, d: e_d, cyc: cyc});
                popped = q[g].pop_front();
                m_beats++;
                if (popped[0]) begin
                    m_start = (g + 1) % N;
                    m_owner = -1;
                    m_beats = 0;
                end else if (m_beats >= MAXB) begin
                    m_err = 1;
                end
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                if (m_owner < 0 && vv[(m_start + k) % N]) m_owner = (m_start + k) % N;
            end
        end
        for (int i = 0; i < N; i++) hold[i] = vv[i] && !(e_wr && g == i);
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int max_cyc, input string name);
        int c = 0;
        while (pending() && c < max_cyc) begin
            run_cycle();
            c++;
        end
        check({name, "_drained"}, 64'(pending()), 64'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        hw_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        //       rst rv     last   bt nf  busy cg gid rdy    wr src
        tbl.push_back(v(1, 3'b000, 3'b000, 0, 1, 0, 1, 0, 3'b000, 0, 0));
        tbl.push_back(v(0, 3'b010, 3'b000, 0, 1, 0, 0, 0, 3'b000, 0, 0));
        tbl.push_back(v(0, 3'b010, 3'b000, 0, 1, 1, 1, 1, 3'b010, 1, 1));
        tbl.push_back(v(0, 3'b010, 3'b000, 1, 1, 1, 1, 1, 3'b010, 1, 1));
        tbl.push_back(v(0, 3'b010, 3'b000, 2, 1, 1, 1, 1, 3'b010, 1, 1));
        tbl.push_back(v(0, 3'b010, 3'b010, 3, 1, 1, 1, 1, 3'b010, 1, 1));
        tbl.push_back(v(0, 3'b000, 3'b000, 0, 1, 0, 0, 0, 3'b000, 0, 0));
        tbl.push_back(v(0, 3'b001, 3'b000, 0, 1, 0, 0, 0, 3'b000, 0, 0));
        tbl.push_back(v(0, 3'b001, 3'b000, 0, 1, 1, 1, 0, 3'b001, 1, 0));
        tbl.push_back(v(0, 3'b001, 3'b000, 1, 0, 1, 1, 0, 3'b000, 0, 0));
        tbl.push_back(v(0, 3'b001, 3'b000, 1, 0, 1, 1, 0, 3'b000, 0, 0));
        tbl.push_back(v(0, 3'b001, 3'b000, 1, 0, 1, 1, 0, 3'b000, 0, 0));
        tbl.push_back(v(0, 3'b001, 3'b000, 1, 1, 1, 1, 0, 3'b001, 1, 0));
        tbl.push_back(v(0, 3'b001, 3'b001, 2, 1, 1, 1, 0, 3'b001, 1, 0));
        tbl.push_back(v(0, 3'b100, 3'b000, 0, 1, 0, 0, 0, 3'b000, 0, 0));
        tbl.push_back(v(0, 3'b100, 3'b000, 0, 1, 1, 1, 2, 3'b100, 1, 2));
        tbl.push_back(v(1, 3'b100, 3'b000, 1, 1, 1, 1, 2, 3'b000, 0, 0));
        tbl.push_back(v(0, 3'b101, 3'b000, 0, 1, 0, 1, 0, 3'b000, 0, 0));
        tbl.push_back(v(0, 3'b101, 3'b001, 0, 1, 1, 1, 0, 3'b001, 1, 0));
        tbl.push_back(v(0, 3'b100, 3'b000, 0, 1, 0, 0, 0, 3'b000, 0, 0));
        tbl.push_back(v(0, 3'b100, 3'b100, 0, 1, 1, 1, 2, 3'b100, 1, 2));
        tbl.push_back(v(0, 3'b000, 3'b000, 0, 1, 0, 0, 0, 3'b000, 0, 0));

        foreach (tbl[n]) begin
            vec_t  t;
            beat_t exp_d;
            t = tbl[n];
            rst = t.rst;
            bus.fifo_not_full = t.nf;
            bus.s_rvalid = t.rv;
            for (int i = 0; i < N; i++) bus.s_rdata[i*DW +: DW] = mk(i, t.beat, t.last[i]);
            #1;
            exp_d = t.e_wr ? mk(t.e_src, t.beat, t.last[t.e_src]) : '0;
            check($sformatf("vec%0d_busy", n), 64'(busy), 64'(t.e_busy));
            if (t.chk_gid) check($sformatf("vec%0d_grant_id", n), 64'(gid), 64'(t.e_gid));
            check($sformatf("vec%0d_s_rready", n), 64'(bus.s_rready), 64'(t.e_rdy));
            check($sformatf("vec%0d_fifo_wr_en", n), 64'(bus.fifo_wr_en), 64'(t.e_wr));
            check($sformatf("vec%0d_fifo_w_data", n), 64'(bus.fifo_w_data), 64'(exp_d));
            check($sformatf("vec%0d_burst_err", n), 64'(err), 64'(0));
            @(posedge clk);
            #1;
        end

        // Round-robin with every source requesting two 2-beat bursts.
        hw_reset();
        for (int r = 0; r < 2; r++)
            for (int s = 0; s < N; s++) push_burst(s, 2, r * 2);
        drain(100, "rr");
        check("rr_log_len", 64'(log_q.size()), 64'(12));
        if (log_q.size() == 12) begin
            for (int b = 0; b < 6; b++) begin
                check($sformatf("rr_order%0d_a", b), 64'(log_q[2*b].src), 64'(b % N));
                check($sformatf("rr_order%0d_b", b), 64'(log_q[2*b+1].src), 64'(b % N));
                if (b > 0)
                    check($sformatf("rr_gap%0d", b), 64'(log_q[2*b].cyc - log_q[2*b-1].cyc), 64'(2));
            end
        end

        // Back-pressure for three cycles over a held beat.
        hw_reset();
        q[0].push_back(mk(0, 0, 0));
        q[0].push_back({8'h5A, 32'hDEADBEEF, 2'b00, 1'b0});
        q[0].push_back(mk(0, 2, 1));
        nf_q = '{1, 1, 0, 0, 0};
        drain(50, "stall");
        begin
            int hits = 0;
            foreach (log_q[k]) if (log_q[k].d == {8'h5A, 32'hDEADBEEF, 2'b00, 1'b0}) hits++;
            check("stall_held_beat_once", 64'(hits), 64'(1));
        end
        check("stall_log_len", 64'(log_q.size()), 64'(3));
        if (log_q.size() == 3) check("stall_gap", 64'(log_q[1].cyc - log_q[0].cyc), 64'(4));

        // Exactly MAX_BEATS beats with RLAST on the last: no error.
        hw_reset();
        push_burst(1, 16, 0);
        drain(60, "len16");
        check("len16_no_err", 64'(err), 64'(0));

        // 17-beat burst from source 2: error after the 16th non-last beat, sticky.
        hw_reset();
        push_burst(2, 17, 0);
        drain(60, "len17");
        check("len17_err", 64'(err), 64'(1));
        check("len17_log_len", 64'(log_q.size()), 64'(17));
        push_burst(0, 2, 0);
        drain(20, "after_err");
        check("err_sticky", 64'(err), 64'(1));

        // Requests arriving while source 0 holds the grant.
        hw_reset();
        push_burst(0, 4, 0);
        repeat (3) run_cycle();
        push_burst(1, 2, 0);
        push_burst(2, 2, 0);
        drain(50, "late_req");
        check("late_log_len", 64'(log_q.size()), 64'(8));
        if (log_q.size() == 8) begin
            for (int k = 0; k < 8; k++)
                check($sformatf("late_src%0d", k), 64'(log_q[k].src), 64'(k < 4 ? 0 : (k < 6 ? 1 : 2)));
        end

        // Random traffic: gated valids, random back-pressure, occasional overlong bursts.
        hw_reset();
        rand_valid = 1;
        nf_pct = 75;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0) begin
                int s;
                int len;
                s = $urandom_range(0, N - 1);
                len = ($urandom_range(0, 19) == 0) ? 18 : $urandom_range(1, 4);
                if (q[s].size() < 8) begin
                    for (int b = 0; b < len; b++) begin
                        beat_t d;
                        d = {11'($urandom), 32'($urandom)};
                        d[0] = (b == len - 1);
                        q[s].push_back(d);
                    end
                end
            end
            run_cycle();
        end
        drain(600, "random");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/axi_r_resp_arbiter.md
Name: axi_r_resp_arbiter

Overview:
Single-clock arbiter that shares the write port of one 43-bit R-channel async FIFO among NUM_SLV read-response sources on the bus side. It grants one source at a time and holds the grant for a whole burst, until the RLAST beat. Beats are forwarded into the FIFO write interface under FIFO back-pressure. Grant order is round-robin, and bursts that exceed MAX_BEATS without RLAST are reported.

Parameters:
NUM_SLV, 3, number of response sources (2..8)
DATA_W, 43, packed R-beat width: [42:35] RID, [34:3] RDATA, [2:1] RRESP, [0] RLAST
MAX_BEATS, 16, beats allowed per burst before error is flagged (power of 2, ≤256)

Ports:
clk  in  1  system clock (FIFO write-side clock)
rst  in  1  synchronous active-high reset
s_rvalid  in  NUM_SLV  per-source beat valid
s_rdata  in  NUM_SLV*DATA_W  per-source packed beats; source i occupies bits [i*DATA_W +: DATA_W]
s_rready  out  NUM_SLV  per-source beat accept
fifo_not_full  in  1  FIFO write-side space available
fifo_wr_en  out  1  FIFO write strobe
fifo_w_data  out  DATA_W  beat written to FIFO
busy  out  1  a burst is granted
grant_id  out  $clog2(NUM_SLV)  index of the granted source; valid while busy
burst_err  out  1  sticky: a burst reached MAX_BEATS beats without RLAST

Behaviour:
- Clock/reset: one clock; reset is synchronous and active-high. All state samples on posedge clk.
- Reset values: state=IDLE, rr_ptr=0, grant_id=0, beat_cnt=0, burst_err=0, busy=0.
- While in reset: s_rready=0, fifo_wr_en=0, fifo_w_data=0.
- States:
  - IDLE: if any s_rvalid is set, select the first asserted source scanning from rr_ptr upward with wrap (rr_ptr, rr_ptr+1, …, NUM_SLV-1, 0, …). Register it into grant_id and go to BURST on the next edge. No beat transfers in IDLE. The grant cost is one cycle.
  - BURST: granted source g.
    - s_rready[g] = fifo_not_full. All other s_rready bits are 0.
    - fifo_wr_en = s_rvalid[g] & fifo_not_full.
    - fifo_w_data = s_rdata slice g when fifo_wr_en is high, else 0.
    - The path is combinational, so zero added latency per beat.
- Beat transfer = s_rvalid[g] & fifo_not_full. Each transfer increments beat_cnt.
- Transfer with RLAST (bit 0) = 1:
  - On the next edge go to IDLE, set rr_ptr = (g+1) mod NUM_SLV, and clear beat_cnt.
  - The same source may win again only after the other requesters in rotation have been scanned.
- Transfer without RLAST when beat_cnt == MAX_BEATS-1:
  - Set burst_err, which stays set until rst.
  - The grant stays held; the arbiter keeps waiting for RLAST and is never forcibly released.
  - beat_cnt saturates at MAX_BEATS-1.
- fifo_not_full low: s_rready[g]=0 and no write. The source must hold its beat. State, grant_id and beat_cnt are unchanged.
- s_rvalid[g] dropping mid-burst: the grant is held and no write occurs.
- s_rvalid of non-granted sources: ignored during BURST; they stay pending for the next arbitration.
- Single requester: back-to-back bursts from that source each incur one IDLE cycle between the RLAST beat and the next first beat.
- Reset mid-burst: on the next edge the block is in IDLE and all outputs are at reset values. The partially transferred burst is abandoned; the FIFO's own reset is handled separately.
- busy = (state == BURST).

Decomposition:
- Shared package axi_r_pkg:
  - field widths RID_W=8, RDATA_W=32, RRESP_W=2
  - DATA_W and field bit positions (RLAST_BIT=0)
  - state enum {IDLE, BURST}
- Sub-module rr_pick: combinational round-robin first-one finder. Inputs: req vector and start pointer. Outputs: index and any flag. It is reusable by the AW/AR arbiters.

Test Plan:
- Reset, then s_rvalid=3'b010 with a 4-beat burst (RLAST on beat 4), fifo_not_full=1:
  - grant_id=1 one cycle after the request; 4 consecutive fifo_wr_en pulses with data equal to source 1 beats; busy falls after beat 4.
- s_rvalid=3'b111 continuously, each source sending 2-beat bursts:
  - grant order 0,1,2,0,…; exactly one IDLE cycle between bursts; no beat interleaving.
- Mid-burst fifo_not_full=0 for 3 cycles:
  - s_rready and fifo_wr_en are 0 for those 3 cycles; the held beat (e.g. RID=8'h5A, RDATA=32'hDEADBEEF) is written once after release; no duplicates.
- Source 2 sends 16 beats with RLAST=0, then RLAST=1 on beat 17:
  - burst_err rises after the 16th transfer and stays 1; the grant is released only after beat 17.
- rst asserted on beat 2 of a 4-beat burst:
  - next cycle busy=0, s_rready=0, grant_id=0, burst_err=0; a new request from source 0 is granted normally, starting from rr_ptr=0.
- Two requests arriving while a burst is running (source 0 busy, sources 1 and 2 raise s_rvalid):
  - no effect until RLAST; then source 1 is granted, then source 2.
